mb_serial_rx_crc3: RTL and testbench

Receive end of the serial link. Samples one framed bitstream (8 data bits MSB-first, then 3 CRC-3 bits), shifts the data into a parallel register, and runs the codeword through a CRC-3 LFSR. It presents the byte with a one-cycle valid strobe and a sticky `Error` flag when the remainder is non-zero. It pairs with the parallel-load/shift-out transmitter and CRC-3 generator on the far side of the link.

---
 rtl/mb_serial_pkg.sv | 26 ++
 rtl/mb_serial_rx_crc3_if.sv | 23 ++
 rtl/mb_crc3_lfsr.sv | 24 ++
 rtl/mb_serial_rx_crc3.sv | 89 ++++++++
 tb/tb_mb_serial_rx_crc3.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mb_serial_pkg.sv
// Shared definitions for the serial link: widths, CRC-3 polynomial, FSM encoding.
package mb_serial_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 3;
  localparam int unsigned CNT_W  = 4;

  // x^3 + x + 1
  localparam logic [CRC_W:0] CRC_POLY = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } rx_state_e;

  // One serial LFSR step: fb = bit ^ msb, shift left and fold in the polynomial taps.
  function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] crc,
                                                 input logic             bit_in);
    logic fb;
    fb = bit_in ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY[CRC_W-1:0] : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/mb_serial_rx_crc3_if.sv
// Serial receive link: bit-level inputs toward the receiver, byte-level results back.
interface mb_serial_rx_crc3_if;
  import mb_serial_pkg::*;

  logic              Enable;
  logic              Frame_Start;
  logic              Serial_In;
  logic [DATA_W-1:0] Data_Out;
  logic              Data_Valid;
  logic              Error;
  logic              Busy;

  modport master (
    output Enable, Frame_Start, Serial_In,
    input  Data_Out, Data_Valid, Error, Busy
  );

  modport slave (
    input  Enable, Frame_Start, Serial_In,
    output Data_Out, Data_Valid, Error, Busy
  );

endinterface

// File: rtl/mb_crc3_lfsr.sv
// Serial CRC-3 LFSR with synchronous clear and step enable; remainder is registered.
module mb_crc3_lfsr
  import mb_serial_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             Clear,
  input  logic             Step,
  input  logic             Bit_In,
  output logic [CRC_W-1:0] Rem
);

  // Clear has priority over Step.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Rem <= '0;
    end else if (Clear) begin
      Rem <= '0;
    end else if (Step) begin
      Rem <= crc3_step(Rem, Bit_In);
    end
  end

endmodule

// File: rtl/mb_serial_rx_crc3.sv
// Serial frame receiver: 8 data bits MSB-first plus 3 CRC bits, CRC-3 checked.
module mb_serial_rx_crc3
  import mb_serial_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR,
  mb_serial_rx_crc3_if.slave  link
);

  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [CRC_W-1:0]  crc;
  logic              lfsr_step;

  // A bit is consumed only in DATA/CRC on an Enable cycle not overridden by a restart.
  assign lfsr_step = link.Enable && !link.Frame_Start && ((state == DATA) || (state == CRC));

  mb_crc3_lfsr u_lfsr (
    .CLK    (CLK),
    .CLR    (CLR),
    .Clear  (link.Frame_Start),
    .Step   (lfsr_step),
    .Bit_In (link.Serial_In),
    .Rem    (crc)
  );

  // Frame FSM, bit counter, shift register and registered outputs.
  // Results are loaded on the edge that samples the last CRC bit so they are
  // visible during DONE; the error uses the remainder including that last bit.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      link.Data_Out   <= '0;
      link.Data_Valid <= 1'b0;
      link.Error      <= 1'b0;
      link.Busy       <= 1'b0;
    end else begin
      link.Data_Valid <= 1'b0;
      if (link.Frame_Start) begin
        state      <= DATA;
        cnt        <= '0;
        shreg      <= '0;
        link.Error <= 1'b0;
        link.Busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          DATA: begin
            if (link.Enable) begin
              shreg <= {shreg[DATA_W-2:0], link.Serial_In};
              if (cnt == CNT_W'(DATA_W - 1)) begin
                state <= CRC;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          CRC: begin
            if (link.Enable) begin
              if (cnt == CNT_W'(CRC_W - 1)) begin
                state           <= DONE;
                cnt             <= '0;
                link.Data_Out   <= shreg;
                link.Data_Valid <= 1'b1;
                link.Error      <= (crc3_step(crc, link.Serial_In) != '0);
                link.Busy       <= 1'b0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mb_serial_rx_crc3.sv
// Self-checking bench for mb_serial_rx_crc3: directed table, corner sequences, random frames.
module tb_mb_serial_rx_crc3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   n_valid;
  logic [7:0] last_data;
  logic       last_err;

  mb_serial_rx_crc3_if bus ();

  mb_serial_rx_crc3 dut (
    .CLK  (clk),
    .CLR  (rst),
    .link (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] crc;
    int         stall;
    logic       exp_err;
  } vec_t;

  // Polynomial long division of an 11-bit word by x^3+x+1 (0xB).
  function automatic logic [2:0] poly_mod(input logic [10:0] w);
    logic [10:0] r;
    logic [10:0] p;
    r = w;
    p = 11'h00B;
    for (int i = 10; i >= 3; i--) begin
      if (r[i]) r = r ^ (p << (i - 3));
    end
    return r[2:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply inputs, advance one rising edge, then settle just after it.
  task automatic drive(input logic fs, input logic en, input logic si);
    bus.Frame_Start = fs;
    bus.Enable      = en;
    bus.Serial_In   = si;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.Data_Valid === 1'b1) n_valid++;
  endtask

  // Idle cycles with Enable noise; outputs must hold.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("idle_valid", 32'(bus.Data_Valid), 32'd0);
      check("idle_busy",  32'(bus.Busy),       32'd0);
      check("idle_data",  32'(bus.Data_Out),   32'(last_data));
      check("idle_err",   32'(bus.Error),      32'(last_err));
    end
  endtask

  // Start a frame and deliver k bits, leaving it unfinished.
  task automatic abort_prefix(input int k);
    drive(1'b1, 1'b0, 1'b0);
    check("pre_busy", 32'(bus.Busy), 32'd1);
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      check("pre_valid", 32'(bus.Data_Valid), 32'd0);
      check("pre_busy",  32'(bus.Busy),       32'd1);
      check("pre_data",  32'(bus.Data_Out),   32'(last_data));
    end
  endtask

  // Full frame; stall < 0 means random idle gaps. Ends sampling the DONE cycle.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] c, input logic exp_err,
                            input int stall, output int done_cyc);
    logic [10:0] word;
    int          start_cyc;
    int          idles;
    int          n_idle;
    word      = {d, c};
    start_cyc = cyc;
    idles     = 0;
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("busy_rise", 32'(bus.Busy),       32'd1);
    check("err_clear", 32'(bus.Error),      32'd0);
    check("start_nov", 32'(bus.Data_Valid), 32'd0);
    for (int i = 10; i >= 0; i--) begin
      n_idle = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int j = 0; j < n_idle; j++) begin
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        idles++;
        check("stall_busy",  32'(bus.Busy),       32'd1);
        check("stall_valid", 32'(bus.Data_Valid), 32'd0);
        check("stall_data",  32'(bus.Data_Out),   32'(last_data));
      end
      drive(1'b0, 1'b1, word[i]);
      if (i > 0) begin
        check("bit_busy",  32'(bus.Busy),       32'd1);
        check("bit_valid", 32'(bus.Data_Valid), 32'd0);
      end
    end
    check("done_valid",   32'(bus.Data_Valid), 32'd1);
    check("done_data",    32'(bus.Data_Out),   32'(d));
    check("done_err",     32'(bus.Error),      32'(exp_err));
    check("done_busy",    32'(bus.Busy),       32'd0);
    check("done_latency", 32'(cyc - start_cyc), 32'(12 + idles));
    done_cyc  = cyc;
    last_data = d;
    last_err  = exp_err;
  endtask

  initial begin
    vec_t       vecs [6];
    int         dc;
    int         c1;
    int         c2;
    int         vb;
    logic [7:0] d;
    logic [2:0] c;
    logic       e;

    vecs[0] = '{data: 8'hA5, crc: 3'b101, stall: 0, exp_err: 1'b0};
    vecs[1] = '{data: 8'h80, crc: 3'b010, stall: 0, exp_err: 1'b1};
    vecs[2] = '{data: 8'h01, crc: 3'b011, stall: 2, exp_err: 1'b0};
    vecs[3] = '{data: 8'h80, crc: 3'b011, stall: 1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hA5, crc: 3'b100, stall: 0, exp_err: 1'b1};
    vecs[5] = '{data: 8'h01, crc: 3'b000, stall: 3, exp_err: 1'b1};

    n_cmp = 0; n_fail = 0; cyc = 0; n_valid = 0;
    last_data = 8'h00; last_err = 1'b0;
    bus.Frame_Start = 1'b0; bus.Enable = 1'b0; bus.Serial_In = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  32'(bus.Data_Out),   32'd0);
    check("rst_valid", 32'(bus.Data_Valid), 32'd0);
    check("rst_err",   32'(bus.Error),      32'd0);
    check("rst_busy",  32'(bus.Busy),       32'd0);
    rst = 1'b0;
    gap(2);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].crc, vecs[i].exp_err, vecs[i].stall, dc);
      gap(2);
    end

    // Asynchronous reset mid-DATA after 5 bits
    abort_prefix(5);
    #2 rst = 1'b1;
    #1;
    check("arst_data",  32'(bus.Data_Out),   32'd0);
    check("arst_valid", 32'(bus.Data_Valid), 32'd0);
    check("arst_err",   32'(bus.Error),      32'd0);
    check("arst_busy",  32'(bus.Busy),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_data = 8'h00; last_err = 1'b0;
    gap(1);
    send_frame(8'h00, 3'b000, 1'b0, 0, dc);
    gap(1);

    // Abort after 4 bits, then complete frame: exactly one strobe
    vb = n_valid;
    abort_prefix(4);
    send_frame(8'h3C, poly_mod({8'h3C, 3'b000}), 1'b0, 0, dc);
    gap(2);
    check("abort_one_valid", 32'(n_valid - vb), 32'd1);

    // Back-to-back: next start in the DONE cycle
    vb = n_valid;
    send_frame(8'hA5, 3'b101, 1'b0, 0, c1);
    send_frame(8'h80, 3'b011, 1'b0, 0, c2);
    check("b2b_spacing", 32'(c2 - c1), 32'd12);
    gap(1);
    check("b2b_two_valid", 32'(n_valid - vb), 32'd2);

    // Random frames against the division model
    for (int f = 0; f < 40; f++) begin
      gap(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0) abort_prefix(int'($urandom_range(1, 10)));
      d = 8'($urandom);
      c = poly_mod({d, 3'b000});
      if ($urandom_range(0, 3) == 0) c = c ^ 3'($urandom_range(1, 7));
      e = (poly_mod({d, c}) != 3'b000);
      vb = n_valid;
      send_frame(d, c, e, -1, dc);
      check("rnd_one_valid", 32'(n_valid - vb), 32'd1);
    end
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
